// File: rtl/riscv_pkg.sv
// Shared fetch-sequencer types and defaults used by pc_sequencer and its
// pending-redirect buffer.
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    WAIT_GNT = 2'd2
  } pcseq_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  // Misaligned redirect targets are vectored to the trap address.
  function automatic logic [31:0] sel_target(input logic [31:0] target,
                                             input logic [31:0] trap_vec);
    return (target[1:0] != 2'b00) ? trap_vec : target;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending redirect target: captured while a fetch is still un-granted, later
// overwritten by any newer redirect, released when the stale fetch is granted.
module pc_redirect_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] target_i,
  output logic        valid_o,
  output logic [31:0] target_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o  <= 1'b0;
      target_o <= 32'h0;
    end else if (load_i) begin
      valid_o  <= 1'b1;
      target_o <= target_i;
    end else if (clear_i) begin
      valid_o  <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: advances the PC on granted fetches, applies EX-stage
// redirects, and defers a redirect until an outstanding fetch is granted.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             ex_valid_i,
  input  logic             pc_sel_i,
  input  logic [31:0]      branch_target_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic             imem_gnt_i,
  output logic [31:0]      pc_o,
  output logic             flush_o,
  output logic             fetch_kill_o,
  output logic             misalign_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  pcseq_state_e state_q;
  logic [31:0]  pc_q;
  logic         outstanding_q;
  logic         redir;
  logic         misaligned;
  logic [31:0]  tgt;
  logic         pend_valid;
  logic [31:0]  pend_target;
  logic         pend_load;
  logic         pend_clear;
  logic         req_stuck;

  assign redir      = ex_valid_i & pc_sel_i & (state_q != BOOT);
  assign misaligned = (branch_target_i[1:0] != 2'b00);
  assign tgt        = sel_target(branch_target_i, TRAP_VEC);

  // A request raised but not yet granted must be held, even under stall.
  always_comb begin
    imem_req_o = 1'b0;
    case (state_q)
      RUN:      imem_req_o = ~stall_i | outstanding_q;
      WAIT_GNT: imem_req_o = 1'b1;
      default:  imem_req_o = 1'b0;
    endcase
  end

  assign req_stuck    = imem_req_o & ~imem_gnt_i;
  assign flush_o      = redir;
  assign fetch_kill_o = pend_valid & imem_gnt_i;
  assign pc_o         = pc_q;
  assign imem_addr_o  = pc_q;

  // A same-cycle grant releases the buffer; the new target goes straight to pc.
  assign pend_load  = redir & req_stuck & (state_q != BOOT);
  assign pend_clear = (state_q == WAIT_GNT) & imem_gnt_i;

  pc_redirect_buf u_redirect_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (pend_load),
    .clear_i  (pend_clear),
    .target_i (tgt),
    .valid_o  (pend_valid),
    .target_o (pend_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= BOOT;
      pc_q           <= RESET_PC;
      outstanding_q  <= 1'b0;
      misalign_o     <= 1'b0;
      redirect_cnt_o <= '0;
    end else begin
      misalign_o <= redir & misaligned;
      if (redir && (redirect_cnt_o != {CNT_W{1'b1}}))
        redirect_cnt_o <= redirect_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};

      case (state_q)
        BOOT: begin
          state_q       <= RUN;
          outstanding_q <= 1'b0;
        end
        RUN: begin
          outstanding_q <= 1'b0;
          if (redir) begin
            if (req_stuck) state_q <= WAIT_GNT;
            else           pc_q    <= tgt;
          end else if (imem_req_o && imem_gnt_i) begin
            pc_q <= pc_q + INSTR_BYTES;
          end else begin
            outstanding_q <= req_stuck;
          end
        end
        WAIT_GNT: begin
          outstanding_q <= 1'b0;
          if (imem_gnt_i) begin
            pc_q    <= redir ? tgt : pend_target;
            state_q <= RUN;
          end
        end
        default: begin
          state_q       <= BOOT;
          outstanding_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer with a flag-based reference model of the
// fetch/redirect rules and randomized traffic.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] TRAP     = 32'h0000_0100;
  localparam int          TB_CNT_W = 4;
  localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                stall_i = 1'b0;
  logic                ex_valid_i = 1'b0;
  logic                pc_sel_i = 1'b0;
  logic [31:0]         branch_target_i = 32'h0;
  logic                imem_gnt_i = 1'b0;
  logic                imem_req_o;
  logic [31:0]         imem_addr_o;
  logic [31:0]         pc_o;
  logic                flush_o;
  logic                fetch_kill_o;
  logic                misalign_o;
  logic [TB_CNT_W-1:0] redirect_cnt_o;

  int total = 0;
  int bad   = 0;

  // Reference model: fetch address, whether a fetch was left waiting, and an
  // optional deferred redirect.
  logic [31:0] m_pc;
  logic        m_boot;
  logic        m_inflight;
  logic        m_pend_v;
  logic [31:0] m_pend;
  logic        m_mis;
  int          m_cnt;

  pc_sequencer #(
    .RESET_PC (RST_PC),
    .TRAP_VEC (TRAP),
    .CNT_W    (TB_CNT_W)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .ex_valid_i      (ex_valid_i),
    .pc_sel_i        (pc_sel_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .pc_o            (pc_o),
    .flush_o         (flush_o),
    .fetch_kill_o    (fetch_kill_o),
    .misalign_o      (misalign_o),
    .redirect_cnt_o  (redirect_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic m_redir();
    return ex_valid_i & pc_sel_i & ~m_boot;
  endfunction

  function automatic logic m_req();
    if (m_boot) return 1'b0;
    return m_pend_v | m_inflight | ~stall_i;
  endfunction

  function automatic logic [31:0] m_target();
    if (branch_target_i % 4 != 0) return TRAP;
    return branch_target_i;
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_boot = 1'b1; m_inflight = 1'b0;
    m_pend_v = 1'b0; m_pend = 32'h0; m_mis = 1'b0; m_cnt = 0;
  endtask

  task automatic drive(input logic st, input logic ex, input logic sel,
                       input logic [31:0] tgt, input logic g);
    @(negedge clk);
    stall_i = st; ex_valid_i = ex; pc_sel_i = sel;
    branch_target_i = tgt; imem_gnt_i = g;
    #1;
  endtask

  // Apply the current inputs to the model, then let the DUT clock.
  task automatic advance();
    logic r, q, g;
    logic [31:0] t;
    r = m_redir(); q = m_req(); g = imem_gnt_i; t = m_target();
    m_mis = r && (branch_target_i % 4 != 0);
    if (r && m_cnt < CNT_MAX) m_cnt++;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_pend_v) begin
      if (g) begin m_pc = r ? t : m_pend; m_pend_v = 1'b0; end
      else if (r) m_pend = t;
    end else if (r) begin
      m_inflight = 1'b0;
      if (q && !g) begin m_pend_v = 1'b1; m_pend = t; end
      else m_pc = t;
    end else if (q && g) begin
      m_pc = m_pc + 32'd4; m_inflight = 1'b0;
    end else begin
      m_inflight = q && !g;
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (pc_o !== RST_PC) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc_o, RST_PC); end
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req_o); end
    total++; if (misalign_o !== 1'b0 || fetch_kill_o !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", misalign_o, fetch_kill_o); end
    total++; if (redirect_cnt_o !== '0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", redirect_cnt_o); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_boot_fetch();
    drive(0, 0, 0, 0, 1);
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL boot_req got=%b want=0", imem_req_o); end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * i)) begin bad++; $display("FAIL seq_addr%0d got=%b/%h want=1/%h", i, imem_req_o, imem_addr_o, 32'(4 * i)); end
      if (i < 2) advance();
    end
    total++; if (redirect_cnt_o !== '0) begin bad++; $display("FAIL seq_cnt got=%0d want=0", redirect_cnt_o); end
    advance();
  endtask

  task automatic test_branch_run();
    drive(0, 1, 1, 32'h40, 1);
    total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL br_flush got=%b want=1", flush_o); end
    advance();
    drive(0, 0, 0, 0, 1);
    total++; if (pc_o !== 32'h40 || imem_addr_o !== 32'h40) begin bad++; $display("FAIL br_pc got=%h want=00000040", pc_o); end
    total++; if (redirect_cnt_o !== 4'd1) begin bad++; $display("FAIL br_cnt got=%0d want=1", redirect_cnt_o); end
    advance();
  endtask

  task automatic test_outstanding_redirect();
    drive(0, 1, 1, 32'h8, 1);
    advance();
    drive(0, 1, 1, 32'h80, 0);
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || flush_o !== 1'b1) begin bad++; $display("FAIL wg_enter got=%b/%h/%b want=1/00000008/1", imem_req_o, imem_addr_o, flush_o); end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(i == 1, 0, 0, 0, 0);
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8 || fetch_kill_o !== 1'b0) begin bad++; $display("FAIL wg_hold%0d got=%b/%h/%b want=1/00000008/0", i, imem_req_o, imem_addr_o, fetch_kill_o); end
      advance();
    end
    drive(0, 0, 0, 0, 1);
    total++; if (fetch_kill_o !== 1'b1) begin bad++; $display("FAIL wg_kill got=%b want=1", fetch_kill_o); end
    advance();
    drive(0, 0, 0, 0, 0);
    total++; if (pc_o !== 32'h80 || fetch_kill_o !== 1'b0) begin bad++; $display("FAIL wg_pc got=%h/%b want=00000080/0", pc_o, fetch_kill_o); end
    total++; if (redirect_cnt_o !== 4'd3) begin bad++; $display("FAIL wg_cnt got=%0d want=3", redirect_cnt_o); end
    advance();
  endtask

  task automatic test_misalign();
    drive(0, 1, 1, 32'h42, 1);
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_early got=%b want=0", misalign_o); end
    advance();
    drive(0, 0, 0, 0, 1);
    total++; if (misalign_o !== 1'b1 || pc_o !== TRAP) begin bad++; $display("FAIL mis_pulse got=%b/%h want=1/%h", misalign_o, pc_o, TRAP); end
    advance();
    drive(0, 0, 0, 0, 1);
    total++; if (misalign_o !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b want=0", misalign_o); end
    advance();
  endtask

  task automatic test_stall_redirect();
    drive(1, 1, 1, 32'h200, 0);
    total++; if (imem_req_o !== 1'b0 || flush_o !== 1'b1) begin bad++; $display("FAIL st_redir got=%b/%b want=0/1", imem_req_o, flush_o); end
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0);
      total++; if (pc_o !== 32'h200 || imem_req_o !== 1'b0) begin bad++; $display("FAIL st_hold%0d got=%h/%b want=00000200/0", i, pc_o, imem_req_o); end
      advance();
    end
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 0, 0);
    advance();
    drive(1, 1, 1, 32'h300, 0);
    advance();
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0; imem_gnt_i = 1'b1;
    #1;
    model_reset();
    total++; if (pc_o !== RST_PC || imem_req_o !== 1'b0 || fetch_kill_o !== 1'b0) begin bad++; $display("FAIL ar_now got=%h/%b/%b want=%h/0/0", pc_o, imem_req_o, fetch_kill_o, RST_PC); end
    total++; if (redirect_cnt_o !== '0 || misalign_o !== 1'b0) begin bad++; $display("FAIL ar_cnt got=%0d/%b want=0/0", redirect_cnt_o, misalign_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 1);
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL ar_boot got=%b want=0", imem_req_o); end
    advance();
    drive(0, 0, 0, 0, 1);
    total++; if (imem_addr_o !== RST_PC || imem_req_o !== 1'b1) begin bad++; $display("FAIL ar_restart got=%h/%b want=%h/1", imem_addr_o, imem_req_o, RST_PC); end
    advance();
    drive(0, 0, 0, 0, 1);
    total++; if (imem_addr_o !== 32'h4) begin bad++; $display("FAIL ar_next got=%h want=00000004", imem_addr_o); end
    advance();
  endtask

  task automatic test_wrap();
    drive(0, 1, 1, 32'hFFFF_FFFC, 1);
    advance();
    drive(0, 0, 0, 0, 1);
    total++; if (pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h want=fffffffc", pc_o); end
    advance();
    drive(0, 0, 0, 0, 1);
    total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h want=00000000", pc_o); end
    advance();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 1, 32'h10, 1);
      advance();
    end
    drive(0, 0, 0, 0, 1);
    total++; if (redirect_cnt_o !== 4'(CNT_MAX)) begin bad++; $display("FAIL sat_cnt got=%0d want=%0d", redirect_cnt_o, CNT_MAX); end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] t;
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       t = 32'hFFFF_FFFC;
        1:       t = $urandom;
        default: t = {$urandom_range(0, 255), 2'b00};
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 0, t, $urandom_range(0, 1) == 0);
      total++; if (imem_req_o !== m_req()) begin bad++; $display("FAIL rnd_req c%0d got=%b want=%b", i, imem_req_o, m_req()); end
      total++; if (imem_addr_o !== m_pc || pc_o !== m_pc) begin bad++; $display("FAIL rnd_pc c%0d got=%h/%h want=%h", i, pc_o, imem_addr_o, m_pc); end
      total++; if (flush_o !== m_redir()) begin bad++; $display("FAIL rnd_flush c%0d got=%b want=%b", i, flush_o, m_redir()); end
      total++; if (fetch_kill_o !== (m_pend_v & imem_gnt_i)) begin bad++; $display("FAIL rnd_kill c%0d got=%b want=%b", i, fetch_kill_o, m_pend_v & imem_gnt_i); end
      total++; if (misalign_o !== m_mis) begin bad++; $display("FAIL rnd_mis c%0d got=%b want=%b", i, misalign_o, m_mis); end
      total++; if (redirect_cnt_o !== 4'(m_cnt)) begin bad++; $display("FAIL rnd_cnt c%0d got=%0d want=%0d", i, redirect_cnt_o, m_cnt); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_branch_run();
    test_outstanding_redirect();
    test_misalign();
    test_stall_redirect();
    test_async_reset();
    test_wrap();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
